input_shift_register: RTL and testbench
=======================================

Name: input_shift_register

Overview:
Input shift register (ISR) for one PIO state machine. It is the receive-direction counterpart of the output shift register.
- Shifts 1..WIDTH bits of sampled input data into an accumulator.
- Tracks the number of bits accumulated.
- Pushes the accumulated word into the RX FIFO, either on an explicit push command or by autopush at a programmable threshold.
- Stalls the FSM when a push meets a full FIFO.

Parameters:
WIDTH, 32, ISR and FIFO word width. Count/threshold ports are CW = $clog2(WIDTH)+1 bits (6 at default).

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
data_in  input  WIDTH  source bits (pins/x/y/null, selected by FSM); low shift_count bits used
shift_en  input  1  perform one shift this cycle
shift_count  input  CW  bits to shift; 0 encodes WIDTH
shiftdir  input  1  1 = shift right (new bits enter at MSB), 0 = shift left (new bits enter at LSB)
push_req  input  1  explicit push command
push_block  input  1  1 = blocking push, 0 = non-blocking push
isr_clear  input  1  clear ISR and count
autopush_en  input  1  enable autopush
push_threshold  input  CW  autopush threshold; 0 encodes WIDTH
fifo_full  input  1  RX FIFO full status
fifo_push_en  output  1  combinational push strobe to the RX FIFO
fifo_data  output  WIDTH  combinational push data
isr  output  WIDTH  registered ISR contents
isr_count  output  CW  registered bit count, 0..WIDTH
stall  output  1  FSM must hold its PC/instruction
overflow  output  1  sticky drop flag (see Optional Feature)
overflow_clr  input  1  clear overflow

Behaviour:
- Reset (rst=0, async): isr=0, isr_count=0, state=RUN, overflow=0. Combinational outputs fifo_push_en=0, fifo_data=0, stall=0 while in reset.
- Definitions:
  - n = (shift_count==0) ? WIDTH : shift_count.
  - thr = (push_threshold==0) ? WIDTH : push_threshold.
- Shift result S:
  - shiftdir=1: S = {data_in[n-1:0], isr[WIDTH-1:n]}.
  - shiftdir=0: S = {isr[WIDTH-n-1:0], data_in[n-1:0]}.
  - For n=WIDTH: S = data_in.
- Count C = min(isr_count + n, WIDTH); saturates, never wraps.
- States: RUN, PUSH_WAIT, AUTO_WAIT. stall = (state != RUN) (Moore).
- RUN command priority: isr_clear > push_req > shift_en. Lower-priority commands in the same cycle are dropped.
- isr_clear: isr<=0, isr_count<=0. No push.
- push_req, fifo_full=0: fifo_push_en=1 and fifo_data=isr in the same cycle; isr<=0, count<=0.
- push_req, fifo_full=1, push_block=1: no strobe, isr held, go to PUSH_WAIT.
- push_req, fifo_full=1, push_block=0: no strobe; isr<=0, count<=0 (data dropped).
- shift_en, and autopush_en=0 or C<thr: isr<=S, isr_count<=C.
- shift_en, autopush_en=1, C>=thr:
  - fifo_full=0: fifo_push_en=1 and fifo_data=S in the same cycle; isr<=0, count<=0.
  - fifo_full=1: isr<=S, count<=C, go to AUTO_WAIT.
- PUSH_WAIT/AUTO_WAIT:
  - All commands (shift_en, push_req, isr_clear) are ignored.
  - Each cycle fifo_full=1: hold, stall=1.
  - First cycle fifo_full=0: fifo_push_en=1, fifo_data=isr; isr<=0, count<=0, go to RUN. stall is still 1 in this cycle and drops to 0 the next cycle.
- fifo_push_en is at most 1 per cycle and never asserted while fifo_full=1. Back-to-back pushes are legal, because full is sampled combinationally.
- Reset mid-wait: immediately RUN, stall=0, pending word discarded.
- overflow_clr: overflow<=0. A simultaneous set wins.

Optional Feature:
Macro ISR_OVERFLOW_FLAG_EN.
- Defined: overflow is set to 1 on every non-blocking push that meets fifo_full=1. It stays sticky until overflow_clr or reset.
- Undefined: the port remains and is tied to 0; overflow_clr is ignored. No flag register is synthesized.

Test Plan:
1. Assert rst=0 mid-operation with isr=0x1234 -> isr=0, isr_count=0, stall=0, fifo_push_en=0 immediately, without waiting for a clock edge.
2. From reset, shiftdir=0, shift_count=8, data_in=0xA5, two shifts -> isr=0x0000A5A5, isr_count=16. Then shift_count=0, data_in=0xDEADBEEF -> isr=0xDEADBEEF, count=32 (saturated).
3. From reset, shiftdir=1, shift_count=8, data_in=0xA5 -> isr=0xA5000000. Repeat with data_in=0x3C -> isr=0x3CA50000, count=16.
4. autopush_en=1, push_threshold=16, shiftdir=0, shifts of 8 with data 0x12 then 0x34, fifo_full=0 -> second shift cycle fifo_push_en=1, fifo_data=0x00001234; next cycle isr=0, count=0.
5. isr=0xCAFE0000, push_req=1, push_block=1, fifo_full=1 for 3 cycles -> stall=1 for those cycles, no strobe, concurrent shift_en ignored. Then fifo_full=0 -> fifo_push_en=1, fifo_data=0xCAFE0000 in that cycle; stall=0 the following cycle.
6. With ISR_OVERFLOW_FLAG_EN defined: non-blocking push, fifo_full=1, isr=0x55 -> no strobe, isr=0, overflow=1 held until overflow_clr=1 pulse clears it. Undefined build: overflow stays 0.

Source files
------------

// File: rtl/input_shift_register.sv
// Input shift register for one PIO state machine: accumulates sampled input bits and pushes words to the RX FIFO.
// Optional sticky drop flag enabled by defining ISR_OVERFLOW_FLAG_EN.
module input_shift_register #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  input  logic [CW-1:0]    shift_count,
  input  logic             shiftdir,
  input  logic             push_req,
  input  logic             push_block,
  input  logic             isr_clear,
  input  logic             autopush_en,
  input  logic [CW-1:0]    push_threshold,
  input  logic             fifo_full,
  output logic             fifo_push_en,
  output logic [WIDTH-1:0] fifo_data,
  output logic [WIDTH-1:0] isr,
  output logic [CW-1:0]    isr_count,
  output logic             stall,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic [1:0]       dbg_state
);

  // FIFO handshake: a word is transferred in any cycle where fifo_push_en=1;
  // fifo_push_en is only raised while fifo_full=0, so the FIFO always accepts it.

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PUSH_WAIT = 2'd1,
    AUTO_WAIT = 2'd2
  } state_t;

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    n, thr, rshift_amt, cnt_sat, cnt_d;
  logic [CW:0]      cnt_sum;
  logic [WIDTH-1:0] mask, din_m, shift_res, isr_d, push_data;
  logic             auto_hit, push_en, ovf_set;

  // Shift datapath; a zero (or out-of-range) count means a full-width shift.
  always_comb begin
    n          = (shift_count == '0 || shift_count > WIDTH_C) ? WIDTH_C : shift_count;
    thr        = (push_threshold == '0 || push_threshold > WIDTH_C) ? WIDTH_C : push_threshold;
    mask       = ~({WIDTH{1'b1}} << n);
    din_m      = data_in & mask;
    rshift_amt = WIDTH_C - n;
    if (shiftdir) shift_res = (isr >> n) | (din_m << rshift_amt);
    else          shift_res = (isr << n) | din_m;
    cnt_sum    = {1'b0, isr_count} + {1'b0, n};
    cnt_sat    = (cnt_sum > {1'b0, WIDTH_C}) ? WIDTH_C : cnt_sum[CW-1:0];
    auto_hit   = autopush_en && (cnt_sat >= thr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (!isr_clear && push_req && fifo_full && push_block)
          state_d = PUSH_WAIT;
        else if (!isr_clear && !push_req && shift_en && auto_hit && fifo_full)
          state_d = AUTO_WAIT;
      end
      PUSH_WAIT, AUTO_WAIT: begin
        if (!fifo_full) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    push_en   = 1'b0;
    push_data = '0;
    isr_d     = isr;
    cnt_d     = isr_count;
    ovf_set   = 1'b0;
    case (state_q)
      RUN: begin
        if (isr_clear) begin
          isr_d = '0;
          cnt_d = '0;
        end else if (push_req) begin
          if (!fifo_full) begin
            push_en   = 1'b1;
            push_data = isr;
            isr_d     = '0;
            cnt_d     = '0;
          end else if (!push_block) begin
            isr_d   = '0;
            cnt_d   = '0;
            ovf_set = 1'b1;
          end
        end else if (shift_en) begin
          if (auto_hit && !fifo_full) begin
            push_en   = 1'b1;
            push_data = shift_res;
            isr_d     = '0;
            cnt_d     = '0;
          end else begin
            isr_d = shift_res;
            cnt_d = cnt_sat;
          end
        end
      end
      default: begin
        if (!fifo_full) begin
          push_en   = 1'b1;
          push_data = isr;
          isr_d     = '0;
          cnt_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isr       <= '0;
      isr_count <= '0;
    end else begin
      isr       <= isr_d;
      isr_count <= cnt_d;
    end
  end

  // Strobe and data are forced low while reset is held, independent of inputs.
  assign fifo_push_en = push_en & rst;
  assign fifo_data    = rst ? push_data : '0;
  assign stall        = (state_q != RUN);
  assign dbg_state    = state_q;

`ifdef ISR_OVERFLOW_FLAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf_set ^ overflow_clr;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_input_shift_register.sv
// Directed self-checking bench for input_shift_register (WIDTH=32).
module tb_input_shift_register;

  localparam int WIDTH = 32;
  localparam int CW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             shift_en;
  logic [CW-1:0]    shift_count;
  logic             shiftdir;
  logic             push_req;
  logic             push_block;
  logic             isr_clear;
  logic             autopush_en;
  logic [CW-1:0]    push_threshold;
  logic             fifo_full;
  logic             fifo_push_en;
  logic [WIDTH-1:0] fifo_data;
  logic [WIDTH-1:0] isr;
  logic [CW-1:0]    isr_count;
  logic             stall;
  logic             overflow;
  logic             overflow_clr;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic exp_ovf;

  input_shift_register #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .shift_en(shift_en),
    .shift_count(shift_count), .shiftdir(shiftdir), .push_req(push_req),
    .push_block(push_block), .isr_clear(isr_clear), .autopush_en(autopush_en),
    .push_threshold(push_threshold), .fifo_full(fifo_full),
    .fifo_push_en(fifo_push_en), .fifo_data(fifo_data), .isr(isr),
    .isr_count(isr_count), .stall(stall), .overflow(overflow),
    .overflow_clr(overflow_clr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    shift_en = 0; push_req = 0; isr_clear = 0; overflow_clr = 0;
  endtask

  initial begin
    rst = 0; data_in = '0; shift_en = 0; shift_count = '0; shiftdir = 0;
    push_req = 0; push_block = 0; isr_clear = 0; autopush_en = 0;
    push_threshold = '0; fifo_full = 0; overflow_clr = 0;
    #1;
    check("rst_isr", isr, 0);
    check("rst_count", isr_count, 0);
    check("rst_stall", stall, 0);
    check("rst_ovf", overflow, 0);
    tick();
    rst = 1;
    tick();

    // Left shifts of 8, then a full-width shift that saturates the count.
    shiftdir = 0; shift_count = 8; data_in = 32'hA5; shift_en = 1;
    tick();
    check("l8_isr", isr, 32'h000000A5);
    check("l8_count", isr_count, 8);
    tick();
    check("l16_isr", isr, 32'h0000A5A5);
    check("l16_count", isr_count, 16);
    shift_count = 0; data_in = 32'hDEADBEEF;
    tick();
    check("l32_isr", isr, 32'hDEADBEEF);
    check("l32_count_sat", isr_count, 32);
    shift_count = 8; data_in = 32'hFFFFFF01;
    tick();
    check("lsat_isr", isr, 32'hADBEEF01);
    check("lsat_count", isr_count, 32);

    // Reset asserted mid-wait must take effect without a clock edge.
    shift_en = 0; isr_clear = 1;
    tick();
    isr_clear = 0; shift_en = 1; shift_count = 16; data_in = 32'h1234;
    tick();
    check("pre_rst_isr", isr, 32'h1234);
    shift_en = 0; push_req = 1; push_block = 1; fifo_full = 1;
    tick();
    check("pre_rst_stall", stall, 1);
    #2;
    rst = 0; fifo_full = 0;
    #1;
    check("async_isr", isr, 0);
    check("async_count", isr_count, 0);
    check("async_stall", stall, 0);
    check("async_push_en", fifo_push_en, 0);
    check("async_fifo_data", fifo_data, 0);
    idle_inputs();
    tick();
    rst = 1;
    tick();

    // Right shifts: new bits enter at the MSB end.
    shiftdir = 1; shift_count = 8; data_in = 32'hA5; shift_en = 1;
    tick();
    check("r8_isr", isr, 32'hA5000000);
    data_in = 32'h3C;
    tick();
    check("r16_isr", isr, 32'h3CA50000);
    check("r16_count", isr_count, 16);

    // Autopush at threshold 16 with FIFO space.
    shift_en = 0; isr_clear = 1;
    tick();
    isr_clear = 0; autopush_en = 1; push_threshold = 16; shiftdir = 0;
    shift_count = 8; data_in = 32'h12; shift_en = 1;
    #1;
    check("ap_first_no_push", fifo_push_en, 0);
    tick();
    check("ap_first_isr", isr, 32'h12);
    data_in = 32'h34;
    #1;
    check("ap_push_en", fifo_push_en, 1);
    check("ap_fifo_data", fifo_data, 32'h00001234);
    tick();
    check("ap_isr_cleared", isr, 0);
    check("ap_count_cleared", isr_count, 0);

    // Autopush meeting a full FIFO parks in the wait state with the word kept.
    data_in = 32'h56;
    tick();
    data_in = 32'h78; fifo_full = 1;
    #1;
    check("apw_no_push", fifo_push_en, 0);
    tick();
    shift_en = 0;
    check("apw_isr", isr, 32'h5678);
    check("apw_count", isr_count, 16);
    check("apw_stall", stall, 1);
    fifo_full = 0;
    #1;
    check("apw_push_en", fifo_push_en, 1);
    check("apw_fifo_data", fifo_data, 32'h5678);
    check("apw_stall_last", stall, 1);
    tick();
    check("apw_stall_drop", stall, 0);
    check("apw_isr_cleared", isr, 0);
    autopush_en = 0;

    // Blocking push against a full FIFO for three cycles, with ignored shifts.
    shiftdir = 1; shift_count = 16; data_in = 32'hCAFE; shift_en = 1;
    tick();
    check("bp_isr_setup", isr, 32'hCAFE0000);
    shift_en = 0; push_req = 1; push_block = 1; fifo_full = 1;
    #1;
    check("bp_no_push", fifo_push_en, 0);
    tick();
    push_req = 0; shift_en = 1; data_in = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      check("bp_wait_stall", stall, 1);
      check("bp_wait_push", fifo_push_en, 0);
      check("bp_wait_isr", isr, 32'hCAFE0000);
      tick();
    end
    fifo_full = 0;
    #1;
    check("bp_push_en", fifo_push_en, 1);
    check("bp_fifo_data", fifo_data, 32'hCAFE0000);
    check("bp_stall_last", stall, 1);
    shift_en = 0;
    tick();
    check("bp_stall_drop", stall, 0);
    check("bp_isr_cleared", isr, 0);

    // isr_clear outranks a simultaneous push.
    shiftdir = 0; shift_count = 8; data_in = 32'h77; shift_en = 1;
    tick();
    shift_en = 0; isr_clear = 1; push_req = 1;
    #1;
    check("prio_no_push", fifo_push_en, 0);
    tick();
    check("prio_isr", isr, 0);
    idle_inputs();

    // Non-blocking push meeting a full FIFO drops the word.
`ifdef ISR_OVERFLOW_FLAG_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    shift_count = 8; data_in = 32'h55; shift_en = 1;
    tick();
    check("nb_isr_setup", isr, 32'h55);
    shift_en = 0; push_req = 1; push_block = 0; fifo_full = 1;
    #1;
    check("nb_no_push", fifo_push_en, 0);
    tick();
    push_req = 0;
    check("nb_isr_dropped", isr, 0);
    check("nb_stall", stall, 0);
    check("nb_ovf_set", overflow, exp_ovf);
    tick();
    check("nb_ovf_held", overflow, exp_ovf);
    overflow_clr = 1;
    tick();
    overflow_clr = 0;
    check("nb_ovf_cleared", overflow, 0);
    fifo_full = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
